// File: rtl/control_sequencer.sv
// Microprogrammed next-state sequencer for the multicycle MIPS control unit.
// Optional memory-timeout trap is enabled by defining MOC_TIMEOUT_EN.
module control_sequencer #(
  parameter int unsigned STATE_W        = 7,
  parameter int unsigned FETCH_STATE    = 1,
  parameter int unsigned TRAP_STATE     = 127,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [STATE_W-1:0] State_Sel,
  input  logic [2:0]         Ns_Mode,
  input  logic [1:0]         Cond_Sel,
  input  logic               Inv,
  input  logic [STATE_W-1:0] CR_Addr,
  input  logic               MOC,
  input  logic               Cond,
  output logic [STATE_W-1:0] State,
  output logic               Stall,
  output logic               Dispatch_Invalid,
  output logic               Timeout
);

  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] NS_INCR     = 3'b000;
  localparam logic [2:0] NS_DISPATCH = 3'b001;
  localparam logic [2:0] NS_JUMP     = 3'b010;
  localparam logic [2:0] NS_BRANCH   = 3'b011;
  localparam logic [2:0] NS_WAIT     = 3'b100;
  localparam logic [2:0] NS_FETCH    = 3'b101;

  localparam logic [1:0] CS_MOC  = 2'b00;
  localparam logic [1:0] CS_COND = 2'b01;
  localparam logic [1:0] CS_ONE  = 2'b10;

  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] state_inc;
  logic               cond_raw;
  logic               cond_eff;
  logic               stall_c;
  logic               dispatch_invalid_c;
  logic [STATE_W-1:0] seq_next;

  assign state_inc = STATE_W'(state_q + STATE_W'(1));

  // Condition source select, optionally inverted.
  always_comb begin
    cond_raw = 1'b0;
    case (Cond_Sel)
      CS_MOC:  cond_raw = MOC;
      CS_COND: cond_raw = Cond;
      CS_ONE:  cond_raw = 1'b1;
      default: cond_raw = 1'b0;
    endcase
    cond_eff = cond_raw ^ Inv;
  end

  // Next state chosen by the microstore mode field; no timeout considered here.
  always_comb begin
    seq_next           = '0;
    stall_c            = 1'b0;
    dispatch_invalid_c = 1'b0;
    case (Ns_Mode)
      NS_INCR: seq_next = state_inc;
      NS_DISPATCH: begin
        // An unrecognised opcode (encoder returns 0) restarts from state 0.
        seq_next           = State_Sel;
        dispatch_invalid_c = (State_Sel == '0);
      end
      NS_JUMP:   seq_next = CR_Addr;
      NS_BRANCH: seq_next = cond_eff ? CR_Addr : state_inc;
      NS_WAIT: begin
        seq_next = cond_eff ? state_inc : state_q;
        stall_c  = ~cond_eff;
      end
      NS_FETCH: seq_next = STATE_W'(FETCH_STATE);
      default:  seq_next = '0;
    endcase
  end

`ifdef MOC_TIMEOUT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             timeout_q, timeout_d;
  logic             expire_c;

  // Completion in the expiring cycle drops Stall, so it naturally beats the trap.
  assign expire_c = stall_c && (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = seq_next;
    timeout_d   = 1'b0;
    stall_cnt_d = '0;
    if (expire_c) begin
      state_d   = STATE_W'(TRAP_STATE);
      timeout_d = 1'b1;
    end else if (stall_c) begin
      stall_cnt_d = CNT_W'(stall_cnt_q + CNT_W'(1));
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign Timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  always_comb begin
    state_d = seq_next;
  end

  assign unused_timeout_cfg = ^{TRAP_STATE, TIMEOUT_CYCLES, CNT_W};
  assign Timeout            = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign State            = state_q;
  assign Stall            = stall_c;
  assign Dispatch_Invalid = dispatch_invalid_c;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Microprogrammed control-unit sequencer for the multicycle MIPS datapath. It holds the current control state and selects the next state each cycle from one of four sources: the incremented state, the instruction encoder's dispatch target (`State_Sel`), a microstore jump address, or a fixed fetch/reset state. It sits directly downstream of the instruction-to-state encoder. Its `State` output addresses the microstore, which returns the next-state control fields for the current state.

## Interface
Parameters:
- `STATE_W`, 7: state width; must match the encoder's `State_Sel` width.
- `FETCH_STATE`, 1: first state of the instruction-fetch microroutine.
- `TRAP_STATE`, 127: target state on memory timeout.
- `TIMEOUT_CYCLES`, 16: maximum consecutive stalled cycles before a trap (range 2..255).

Ports:
- `Clk`  in  1  single clock; all state changes on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `State_Sel`  in  STATE_W  dispatch target from the instruction encoder; 0 means unrecognised instruction.
- `Ns_Mode`  in  3  next-state mode from the microstore for the current state.
- `Cond_Sel`  in  2  condition source: 00 `MOC`, 01 `Cond`, 10 constant 1, 11 constant 0.
- `Inv`  in  1  inverts the selected condition.
- `CR_Addr`  in  STATE_W  microstore jump address.
- `MOC`  in  1  memory operation complete.
- `Cond`  in  1  ALU/branch condition flag.
- `State`  out  STATE_W  current state, registered.
- `Stall`  out  1  combinational; high while the sequencer holds in a wait state.
- `Dispatch_Invalid`  out  1  combinational; high in a dispatch cycle when `State_Sel` == 0.
- `Timeout`  out  1  registered, one-cycle pulse on a memory timeout.

## Operation
- Effective condition: `c = sel(Cond_Sel) XOR Inv`.
- Next state by `Ns_Mode`:
  - 000 increment: `State+1`, wrapping 127 -> 0.
  - 001 dispatch: `State_Sel`. A value of 0 restarts from reset state 0 and asserts `Dispatch_Invalid`.
  - 010 jump: `CR_Addr`.
  - 011 branch: if `c`, go to `CR_Addr`; otherwise increment.
  - 100 wait: if `c`, increment; otherwise hold `State` and assert `Stall`.
  - 101 fetch: go to `FETCH_STATE`.
  - 110 and 111 (reserved): go to state 0.
- Stall counter: an 8-bit counter that increments on each cycle where `Stall` is high and clears on any cycle where `Stall` is low.
- When the counter equals `TIMEOUT_CYCLES-1` and `Stall` is still high (macro enabled):
  - the next state is `TRAP_STATE`;
  - `Timeout` is 1 for exactly the first cycle in `TRAP_STATE`;
  - the counter clears.
- `Dispatch_Invalid` and `Stall` are purely decode of the current inputs; they carry no state.

## Timing
- Reset values (asynchronous, immediate on `Reset_n` low): `State`=0, stall counter=0, `Timeout`=0. Reset asserted mid-wait aborts the wait with no trap.
- First rising edge after `Reset_n` deasserts: the state transitions per the microstore fields for state 0.
- Latency: one clock per state. Inputs are sampled on the rising edge, and `State` updates in the same edge.
- A wait completes on the edge where `c`=1. If `MOC` rises in the same cycle the counter would expire, completion wins: the sequencer increments with no trap.
- Dispatch uses `State_Sel` as sampled at that edge. The encoder's instruction input must be stable during the dispatch cycle.

## Configuration
- `MOC_TIMEOUT_EN` defined:
  - stall counter and trap logic are present;
  - `Timeout` behaves as specified above.
- `MOC_TIMEOUT_EN` undefined:
  - there is no counter;
  - a wait holds indefinitely until `c`=1;
  - `Timeout` is tied 0;
  - `TRAP_STATE` and `TIMEOUT_CYCLES` are unused.

## Test plan
- Reset and increment: `Reset_n`=0, then release with `Ns_Mode`=000 -> `State`=0 during reset, then 1, 2, 3 on successive edges. Forcing 127 with increment -> 0 next.
- Dispatch: state with `Ns_Mode`=001, `State_Sel`=13 (load) -> `State`=13 next edge. `State_Sel`=0 -> `Dispatch_Invalid`=1 and `State`=0 next.
- Branch: `Ns_Mode`=011, `Cond_Sel`=01, `Cond`=1, `CR_Addr`=40 -> `State`=40. Same with `Inv`=1 -> `State`+1.
- Wait on MOC: `Ns_Mode`=100, `Cond_Sel`=00, `MOC` low for 5 cycles -> `Stall`=1 and `State` held for 5 cycles. `MOC`=1 -> `State`+1, `Stall`=0.
- Timeout (macro on, `TIMEOUT_CYCLES`=16): `MOC` held 0 -> `State`=127 after 16 stalled cycles and `Timeout`=1 for one cycle. Repeat with `MOC`=1 on the 16th stalled cycle -> increment, no trap.
- Reset mid-wait: `Reset_n`=0 after 8 stalled cycles -> `State`=0 immediately, counter cleared; a subsequent wait lasts a full 16 cycles before trapping.
